pc_sequencer: RTL and testbench

//  Controls when and to what value the program counter moves. Muxes the next PC (PC+4 / branch / jump),

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer_pc_next_mux.sv | 35 +++
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings and constants for the PC sequencer
package pc_sequencer_pkg;

    localparam int NBITS_DEF = 32;
    localparam int PC_INC    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_HALTED    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - pipeline-side signals between the PC sequencer, hazard unit and PC register
interface pc_sequencer_if #(
    parameter int NBITS = 32
) ();

    logic             i_stall;
    logic             i_jump;
    logic [NBITS-1:0] i_jump_target;
    logic             i_branch_taken;
    logic [NBITS-1:0] i_branch_target;
    logic             i_halt;
    logic [NBITS-1:0] i_pc;
    logic [NBITS-1:0] o_npc;
    logic             o_pipe_en;
    logic             o_flush_if;

    modport master (
        input  i_stall, i_jump, i_jump_target, i_branch_taken, i_branch_target, i_halt, i_pc,
        output o_npc, o_pipe_en, o_flush_if
    );

    modport slave (
        output i_stall, i_jump, i_jump_target, i_branch_taken, i_branch_target, i_halt, i_pc,
        input  o_npc, o_pipe_en, o_flush_if
    );

endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// rtl/pc_sequencer_pc_next_mux.sv - stall/jump/branch/PC+4 priority mux with target alignment
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             en,
    input  logic             stall,
    input  logic             jump,
    input  logic [NBITS-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [NBITS-1:0] branch_target,
    input  logic [NBITS-1:0] pc,
    output logic [NBITS-1:0] npc,
    output logic             redirect
);

    // Stall beats any redirect: ID re-resolves the same instruction next cycle.
    always_comb begin
        npc      = pc;
        redirect = 1'b0;
        if (en && !stall) begin
            if (jump) begin
                npc      = {jump_target[NBITS-1:2], 2'b00};
                redirect = 1'b1;
            end else if (branch_taken) begin
                npc      = {branch_target[NBITS-1:2], 2'b00};
                redirect = 1'b1;
            end else begin
                npc = pc + NBITS'(PC_INC);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - run/step/drain/halt control of the program counter and pipeline enable
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int NBITS        = NBITS_DEF,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNTW         = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_step_mode,
    input  logic            i_start,
    input  logic            i_step,
    pc_sequencer_if.master  bus,
    output logic            o_halted,
    output logic [2:0]      o_state,
    output logic [CNTW-1:0] o_cycles
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    seq_state_t     state;
    seq_state_t     state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic           pipe_en;
    logic           fetch_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            o_cycles  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DRAIN && drain_cnt != DRAIN_LAST)
                drain_cnt <= drain_cnt + DCW'(1);
            else
                drain_cnt <= '0;
            if (pipe_en)
                o_cycles <= o_cycles + CNTW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        pipe_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start)
                    state_nxt = i_step_mode ? ST_STEP_WAIT : ST_RUN;
            end
            ST_RUN: begin
                pipe_en = 1'b1;
                if (bus.i_halt)
                    state_nxt = ST_DRAIN;
            end
            ST_STEP_WAIT: begin
                if (i_step)
                    state_nxt = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: begin
                pipe_en   = 1'b1;
                state_nxt = bus.i_halt ? ST_DRAIN : ST_STEP_WAIT;
            end
            ST_DRAIN: begin
                pipe_en = 1'b1;
                if (drain_cnt == DRAIN_LAST)
                    state_nxt = ST_HALTED;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // While draining, older instructions retire but fetch stays frozen and redirects are dropped.
    assign fetch_en = pipe_en && (state != ST_DRAIN);

    pc_next_mux #(.NBITS(NBITS)) u_next_mux (
        .en            (fetch_en),
        .stall         (bus.i_stall),
        .jump          (bus.i_jump),
        .jump_target   (bus.i_jump_target),
        .branch_taken  (bus.i_branch_taken),
        .branch_target (bus.i_branch_target),
        .pc            (bus.i_pc),
        .npc           (bus.o_npc),
        .redirect      (bus.o_flush_if)
    );

    assign bus.o_pipe_en = pipe_en;
    assign o_state       = state;
    assign o_halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed vectors
module tb_pc_sequencer;

    localparam int K_NPC = 0, K_PE = 1, K_FL = 2, K_ST = 3, K_HLT = 4, K_CYC = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_mode, start, step;
    logic        halted;
    logic [2:0]  st;
    logic [31:0] cycles;
    exp_t        q[$];
    int          applied = 0;
    int          errors  = 0;
    bit          done    = 1'b0;

    pc_sequencer_if #(.NBITS(32)) bus ();

    pc_sequencer #(.NBITS(32), .DRAIN_CYCLES(4), .CNTW(32)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_step_mode (step_mode),
        .i_start     (start),
        .i_step      (step),
        .bus         (bus),
        .o_halted    (halted),
        .o_state     (st),
        .o_cycles    (cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int kind);
        case (kind)
            K_NPC:   return bus.o_npc;
            K_PE:    return {31'd0, bus.o_pipe_en};
            K_FL:    return {31'd0, bus.o_flush_if};
            K_ST:    return {29'd0, st};
            K_HLT:   return {31'd0, halted};
            default: return cycles;
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle at the inactive edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            applied++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    end

    task automatic push(string nm, int kind, logic [31:0] v);
        exp_t e;
        e.name = nm; e.kind = kind; e.val = v;
        q.push_back(e);
    endtask

    task automatic expect_st(string nm, logic [2:0] s, logic pe, logic [31:0] cyc);
        push({nm, ".state"}, K_ST, {29'd0, s});
        push({nm, ".pipe_en"}, K_PE, {31'd0, pe});
        push({nm, ".halted"}, K_HLT, {31'd0, (s == 3'd5)});
        push({nm, ".cycles"}, K_CYC, cyc);
    endtask

    task automatic expect_pc(string nm, logic [31:0] npc, logic fl);
        push({nm, ".npc"}, K_NPC, npc);
        push({nm, ".flush"}, K_FL, {31'd0, fl});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        bus.i_stall = 0; bus.i_jump = 0; bus.i_branch_taken = 0; bus.i_halt = 0;
        bus.i_jump_target = 0; bus.i_branch_target = 0;
    endtask

    // Four DRAIN cycles with a frozen PC and ignored redirects, then HALTED.
    task automatic drain_check(string nm, logic [31:0] pc, logic [31:0] cyc0);
        for (int i = 0; i < 4; i++) begin
            bus.i_pc = pc; bus.i_jump = 1; bus.i_jump_target = 32'h400; bus.i_halt = 1;
            expect_st(nm, 3'd4, 1'b1, cyc0 + 32'(i));
            expect_pc(nm, pc, 1'b0);
            tick();
        end
        clear_pipe();
        expect_st({nm, "_halted"}, 3'd5, 1'b0, cyc0 + 32'd4);
        expect_pc({nm, "_halted"}, pc, 1'b0);
    endtask

    initial begin
        rst = 1; step_mode = 0; start = 0; step = 0;
        clear_pipe(); bus.i_pc = 0;
        tick(); tick();

        // 1: reset state, then start in continuous mode
        rst = 0; start = 1;
        expect_st("reset", 3'd0, 1'b0, 32'd0);
        expect_pc("reset", 32'h0, 1'b0);
        tick();
        start = 0;
        expect_st("run_entry", 3'd1, 1'b1, 32'd0);
        expect_pc("run_entry", 32'h4, 1'b0);
        tick();

        // 2: jump beats branch; alignment of targets
        bus.i_pc = 32'h4; bus.i_jump = 1; bus.i_branch_taken = 1;
        bus.i_jump_target = 32'h40; bus.i_branch_target = 32'h80;
        expect_pc("jump_prio", 32'h40, 1'b1);
        push("jump_prio.cycles", K_CYC, 32'd1);
        tick();
        bus.i_jump = 0; bus.i_branch_target = 32'h83;
        expect_pc("branch_align", 32'h80, 1'b1);
        tick();
        bus.i_branch_taken = 0; bus.i_jump = 1; bus.i_jump_target = 32'h4B;
        expect_pc("jump_align", 32'h48, 1'b1);
        tick();

        // 3: stall overrides jump; cycles keep counting
        bus.i_pc = 32'h10; bus.i_stall = 1; bus.i_jump = 1; bus.i_jump_target = 32'h40;
        expect_pc("stall_hold", 32'h10, 1'b0);
        push("stall_hold.cycles", K_CYC, 32'd4);
        tick();
        clear_pipe();
        expect_pc("after_stall", 32'h14, 1'b0);
        push("after_stall.cycles", K_CYC, 32'd5);
        tick();

        // 6a: PC+4 wraps
        bus.i_pc = 32'hFFFF_FFFC;
        expect_pc("pc_wrap", 32'h0, 1'b0);
        tick();

        // 5: halt in RUN, drain 4 cycles, halted absorbs start
        bus.i_pc = 32'h20; bus.i_halt = 1;
        expect_st("halt_run", 3'd1, 1'b1, 32'd7);
        expect_pc("halt_run", 32'h24, 1'b0);
        tick();
        drain_check("drain", 32'h20, 32'd8);
        start = 1;
        tick();
        start = 0;
        expect_st("halted_start", 3'd5, 1'b0, 32'd12);
        tick();

        // 4: single-step mode, three pulses five cycles apart
        rst = 1;
        tick();
        rst = 0; step_mode = 1; start = 1; bus.i_pc = 32'h100;
        expect_st("reset2", 3'd0, 1'b0, 32'd0);
        tick();
        start = 0; step_mode = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1;
            expect_st("step_wait", 3'd2, 1'b0, 32'(k));
            tick();
            step = 0;
            expect_st("step_exec", 3'd3, 1'b1, 32'(k));
            expect_pc("step_exec", 32'h104, 1'b0);
            tick();
            for (int j = 0; j < 3; j++) begin
                expect_st("step_idle", 3'd2, 1'b0, 32'(k + 1));
                tick();
            end
        end
        push("step_total.cycles", K_CYC, 32'd3);
        tick();

        // 6b: reset in DRAIN, then a fresh run drains the full 4 cycles again
        rst = 1;
        tick();
        rst = 0; start = 1;
        tick();
        start = 0; bus.i_halt = 1; bus.i_pc = 32'h30;
        tick();
        bus.i_halt = 0;
        expect_st("drain_mid", 3'd4, 1'b1, 32'd1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        expect_st("reset_in_drain", 3'd0, 1'b0, 32'd0);
        expect_pc("reset_in_drain", 32'h30, 1'b0);
        start = 1;
        tick();
        start = 0; bus.i_halt = 1;
        tick();
        drain_check("redrain", 32'h30, 32'd1);
        tick();

        done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!done && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", guard);
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
